leb128_pack_u32: RTL



---
 rtl/leb128_pack_u32.sv | 108 ++++++++++
 1 files changed

// File: rtl/leb128_pack_u32.sv
`default_nettype none
// ============================================================================
// Module  : leb128_pack_u32
// Brief   : Streaming unsigned LEB128 encoder, one u32 in, one byte per cycle.
// Revision: 1.0
// ============================================================================
module leb128_pack_u32 #(
  parameter int MIN_LEN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_last,
  output logic [2:0]  o_idx,
  output logic [2:0]  o_len
);

  localparam logic [0:0] C_ST_IDLE = 1'b0;
  localparam logic [0:0] C_ST_SEND = 1'b1;
  localparam logic [2:0] C_MIN_LEN = 3'(MIN_LEN);

  generate
    if (MIN_LEN < 1 || MIN_LEN > 5) begin : g_min_len_bad
      $error("leb128_pack_u32: MIN_LEN must be in 1..5");
    end
  endgenerate

  logic [0:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  idx_q,   idx_d;
  logic [2:0]  len_q,   len_d;

  logic [2:0]  w_nat_len;
  logic [2:0]  w_new_len;
  logic        w_send;
  logic        w_last;
  logic        w_fire;
  logic        w_accept;

  function automatic logic [2:0] nat_len(input logic [31:0] v);
    if (v[31:28] != 4'd0)      return 3'd5;
    else if (v[27:21] != 7'd0) return 3'd4;
    else if (v[20:14] != 7'd0) return 3'd3;
    else if (v[13:7] != 7'd0)  return 3'd2;
    else                       return 3'd1;
  endfunction

  always_comb begin
    w_nat_len = nat_len(i_data);
    w_new_len = (w_nat_len < C_MIN_LEN) ? C_MIN_LEN : w_nat_len;
    w_send    = (state_q == C_ST_SEND);
    w_last    = w_send & (idx_q == (len_q - 3'd1));
    w_fire    = w_send & o_ready;
    i_ready   = rst_n & (~w_send | (w_fire & w_last));
    w_accept  = i_valid & i_ready;
  end

  // The shift register zero-fills from the top, so padding and the short
  // fifth chunk fall out of the same 7-bit slice.
  always_comb begin
    o_valid = w_send;
    o_last  = w_last;
    o_idx   = idx_q;
    o_len   = len_q;
    o_data  = w_send ? {~w_last, shift_q[6:0]} : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    len_d   = len_q;
    if (w_accept) begin
      state_d = C_ST_SEND;
      shift_d = i_data;
      idx_d   = 3'd0;
      len_d   = w_new_len;
    end else if (w_fire) begin
      if (w_last) begin
        state_d = C_ST_IDLE;
      end else begin
        shift_d = {7'd0, shift_q[31:7]};
        idx_d   = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= C_ST_IDLE;
      shift_q <= 32'd0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

endmodule
`default_nettype wire
